// File: rtl/sevenseg_multi_driver_if.sv
// Interface carrying the channel inputs and the display-side outputs of
// sevenseg_multi_driver.
//   ch_data   packed channel values, channel 0 in the LSBs
//   ch_event  one-cycle "show this channel" pulses, bit 0 has no meaning
//   seg       active-low segments {g..a} per digit, digit 0 in the LSBs
//   shown_ch  channel whose value is currently displayed
//   busy      a conversion is in flight
// The slave modport is the driver's view; master is the producer's view.
interface sevenseg_multi_driver_if #(
  parameter int DATA_W     = 16,
  parameter int NUM_CH     = 3,
  parameter int NUM_DIGITS = 6
);
  localparam int CHW = ($clog2(NUM_CH) > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic [NUM_CH-1:0]        ch_event;
  logic [NUM_DIGITS*7-1:0]  seg;
  logic [CHW-1:0]           shown_ch;
  logic                     busy;

  modport master (output ch_data, output ch_event,
                  input  seg, input shown_ch, input busy);
  modport slave  (input  ch_data, input ch_event,
                  output seg, output shown_ch, output busy);
endinterface

// File: rtl/sevenseg_multi_driver.sv
// Multi-channel active-low 7-segment display driver.
// The top digit carries a per-channel indicator glyph, the lower NUM_DIGITS-1
// digits carry the decimal value of the selected channel. Channel 0 is the
// resting view; an event on channel k>=1 shows that channel for HOLD_CYCLES
// cycles before falling back to channel 0. Binary to BCD conversion is a
// sequential double-dabble, one input bit per cycle.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    sevenseg_multi_driver_if.slave (ch_data, ch_event in;
//          seg, shown_ch, busy out)
module sevenseg_multi_driver #(
  parameter int                  DATA_W      = 16,
  parameter int                  NUM_CH      = 3,
  parameter int                  NUM_DIGITS  = 6,
  parameter int                  HOLD_CYCLES = 25_000_000,
  parameter bit                  LZ_BLANK    = 1'b1,
  parameter logic [NUM_CH*7-1:0] CH_GLYPH    = {7'b1000111, 7'b0001100, 7'b1111111}
) (
  input  logic                    clk,
  input  logic                    rst_n,
  sevenseg_multi_driver_if.slave  bus
);
  localparam int CHW = ($clog2(NUM_CH) > 1) ? $clog2(NUM_CH) : 1;
  localparam int ND  = NUM_DIGITS - 1;
  localparam int BW  = 4 * ND;
  localparam int TW  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int CW  = $clog2(DATA_W + 1);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  // Largest value that fits on the numeric digits; anything above shows dashes.
  localparam logic [63:0] MAX_VAL = pow10(ND) - 64'd1;

  typedef enum logic [1:0] {ST_IDLE, ST_CONV, ST_COMMIT} state_t;

  state_t                 state_q, state_d;
  logic [CHW-1:0]         sel_q, sel_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [DATA_W-1:0]      v_q, v_d;
  logic [DATA_W-1:0]      last_val_q, last_val_d;
  logic [BW-1:0]          bcd_q, bcd_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [CHW-1:0]         csel_q, csel_d;
  logic                   first_q, first_d;
  logic                   ovf_q, ovf_d;
  logic                   busy_q, busy_d;
  logic [NUM_DIGITS*7-1:0] seg_q, seg_d;
  logic [CHW-1:0]         shown_q, shown_d;

  logic                   ev_hit;
  logic [CHW-1:0]         ev_ch;
  logic [DATA_W-1:0]      cur_val;
  logic [6:0]             glyph;
  logic [ND*7-1:0]        digits;
  logic [BW-1:0]          bcd_adj;
  logic                   nz;
  logic [3:0]             nib;

  // Channel 0 is never an event source; the bit is read only to keep it referenced.
  logic unused_ev0;
  assign unused_ev0 = bus.ch_event[0];

  function automatic logic [6:0] digit7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Channel selection and hold timer. The highest event index wins, and an
  // event always beats expiry in the same cycle.
  always_comb begin
    ev_hit  = 1'b0;
    ev_ch   = '0;
    for (int k = 1; k < NUM_CH; k++) begin
      if (bus.ch_event[k]) begin
        ev_hit = 1'b1;
        ev_ch  = CHW'(k);
      end
    end
    sel_d   = sel_q;
    timer_d = timer_q;
    if (ev_hit) begin
      sel_d   = ev_ch;
      timer_d = '0;
    end else if (sel_q != '0) begin
      if (timer_q == TW'(HOLD_CYCLES - 1)) begin
        sel_d   = '0;
        timer_d = '0;
      end else begin
        timer_d = timer_q + TW'(1);
      end
    end
  end

  // The start decision looks at the next selection so an event or expiry
  // launches its conversion in the same cycle it takes effect.
  always_comb begin
    cur_val = bus.ch_data[DATA_W-1:0];
    for (int k = 1; k < NUM_CH; k++) begin
      if (sel_d == CHW'(k)) cur_val = bus.ch_data[k*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    glyph = CH_GLYPH[6:0];
    for (int k = 1; k < NUM_CH; k++) begin
      if (csel_q == CHW'(k)) glyph = CH_GLYPH[7*k +: 7];
    end
  end

  // Double-dabble correction applied before each shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < ND; i++) begin
      if (bcd_adj[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_adj[4*i +: 4] + 4'd3;
    end
  end

  // Digit rendering, scanned from the top so leading zeros can be blanked.
  always_comb begin
    digits = '1;
    nz     = 1'b0;
    nib    = '0;
    for (int i = ND - 1; i >= 0; i--) begin
      nib = bcd_q[4*i +: 4];
      if (nib != 4'd0) nz = 1'b1;
      if (ovf_q) begin
        digits[7*i +: 7] = 7'b0111111;
      end else if (LZ_BLANK && !nz && (i != 0)) begin
        digits[7*i +: 7] = 7'h7F;
      end else begin
        digits[7*i +: 7] = digit7(nib);
      end
    end
  end

  // Conversion FSM. seg, indicator and shown_ch only ever change together in
  // COMMIT, so no partial result is visible.
  always_comb begin
    state_d    = state_q;
    v_d        = v_q;
    last_val_d = last_val_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    csel_d     = csel_q;
    first_d    = first_q;
    ovf_d      = ovf_q;
    busy_d     = busy_q;
    seg_d      = seg_q;
    shown_d    = shown_q;
    case (state_q)
      ST_IDLE: begin
        if (first_q || (sel_d != csel_q) || (cur_val != last_val_q)) begin
          first_d    = 1'b0;
          csel_d     = sel_d;
          last_val_d = cur_val;
          v_d        = cur_val;
          bcd_d      = '0;
          cnt_d      = '0;
          busy_d     = 1'b1;
          if (64'(cur_val) > MAX_VAL) begin
            ovf_d   = 1'b1;
            state_d = ST_COMMIT;
          end else begin
            ovf_d   = 1'b0;
            state_d = ST_CONV;
          end
        end
      end
      ST_CONV: begin
        bcd_d = {bcd_adj[BW-2:0], v_q[DATA_W-1]};
        v_d   = {v_q[DATA_W-2:0], 1'b0};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(DATA_W - 1)) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        seg_d   = {glyph, digits};
        shown_d = csel_q;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      timer_q    <= '0;
      v_q        <= '0;
      last_val_q <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      csel_q     <= '0;
      first_q    <= 1'b1;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      seg_q      <= '1;
      shown_q    <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      timer_q    <= timer_d;
      v_q        <= v_d;
      last_val_q <= last_val_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      csel_q     <= csel_d;
      first_q    <= first_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
      seg_q      <= seg_d;
      shown_q    <= shown_d;
    end
  end

  assign bus.seg      = seg_q;
  assign bus.shown_ch = shown_q;
  assign bus.busy     = busy_q;
endmodule

// File: tb/tb_sevenseg_multi_driver.sv
// Testbench for sevenseg_multi_driver: a table of display requests whose
// expected commits go into a scoreboard queue, popped by a monitor whenever
// busy falls, plus hand-written sequences for hold timing, mid-conversion
// input changes, reset during conversion, and overflow on a wider instance.
module tb_sevenseg_multi_driver;
  localparam int DW   = 16;
  localparam int DW5  = 20;
  localparam int NC   = 3;
  localparam int NDIG = 6;
  localparam int HOLD = 100;
  localparam int LAT  = DW + 2;
  localparam int LAT5 = DW5 + 2;
  localparam int NVEC = 11;
  localparam logic [NDIG*7-1:0] BLANK = '1;

  typedef struct packed {
    logic [NDIG*7-1:0] seg;
    logic [1:0]        ch;
    logic [31:0]       cyc;
    logic [7:0]        tag;
  } exp_t;

  typedef struct packed {
    logic [2:0]        ev;
    logic [1:0]        ch;
    logic [DW-1:0]     val;
    logic [NDIG*7-1:0] seg;
    logic [1:0]        shown;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic busy_prev = 1'b0;
  logic [NDIG*7-1:0] cur0_seg;
  exp_t sb[$];
  vec_t vecs[NVEC];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sevenseg_multi_driver_if #(.DATA_W(DW),  .NUM_CH(NC), .NUM_DIGITS(NDIG)) bus ();
  sevenseg_multi_driver_if #(.DATA_W(DW5), .NUM_CH(NC), .NUM_DIGITS(NDIG)) bus5 ();

  sevenseg_multi_driver #(.DATA_W(DW), .NUM_CH(NC), .NUM_DIGITS(NDIG),
                          .HOLD_CYCLES(HOLD), .LZ_BLANK(1'b1))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  sevenseg_multi_driver #(.DATA_W(DW5), .NUM_CH(NC), .NUM_DIGITS(NDIG),
                          .HOLD_CYCLES(HOLD), .LZ_BLANK(1'b1))
    dut5 (.clk(clk), .rst_n(rst_n), .bus(bus5));

  function automatic logic [6:0] glyph7(input byte c);
    case (c)
      "0": return 7'h40;
      "1": return 7'h79;
      "2": return 7'h24;
      "3": return 7'h30;
      "4": return 7'h19;
      "5": return 7'h12;
      "6": return 7'h02;
      "7": return 7'h78;
      "8": return 7'h00;
      "9": return 7'h10;
      "-": return 7'h3F;
      "P": return 7'h0C;
      "L": return 7'h47;
      default: return 7'h7F;
    endcase
  endfunction

  // Character 0 of the string is the indicator digit, the rest run MSD..LSD.
  function automatic logic [NDIG*7-1:0] s2seg(input string s);
    logic [NDIG*7-1:0] r;
    r = '1;
    for (int i = 0; i < NDIG; i++) r[(NDIG-1-i)*7 +: 7] = glyph7(s[i]);
    return r;
  endfunction

  function automatic exp_t mkExp(input logic [NDIG*7-1:0] s, input int ch, input int c, input int tag);
    exp_t e;
    e.seg = s;
    e.ch  = 2'(ch);
    e.cyc = 32'(c);
    e.tag = 8'(tag);
    return e;
  endfunction

  function automatic vec_t mkVec(input logic [2:0] ev, input int ch, input logic [DW-1:0] val,
                                 input logic [NDIG*7-1:0] s, input int shown);
    vec_t v;
    v.ev    = ev;
    v.ch    = 2'(ch);
    v.val   = val;
    v.seg   = s;
    v.shown = 2'(shown);
    return v;
  endfunction

  task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("[TB] FAIL unexpected_commit: seg=%h shown_ch=%0d cycle=%0d, required no commit",
               bus.seg, bus.shown_ch, cyc);
    end else begin
      e = sb.pop_front();
      if (bus.seg !== e.seg || bus.shown_ch !== e.ch || cyc != int'(e.cyc)) begin
        errors++;
        $display("[TB] FAIL commit_%0d: seg=%h shown_ch=%0d cycle=%0d, required seg=%h shown_ch=%0d cycle=%0d",
                 e.tag, bus.seg, bus.shown_ch, cyc, e.seg, e.ch, e.cyc);
      end
    end
  endtask

  // A commit is the edge where busy drops; sampled on the falling clock edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_prev <= 1'b0;
    end else begin
      if (busy_prev && !bus.busy) checkOutput();
      busy_prev <= bus.busy;
    end
  end

  task automatic waitDrain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: %0d commits outstanding, required 0", sb.size());
      sb.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic waitUntil(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int tag);
    bus.ch_data[int'(v.ch)*DW +: DW] = v.val;
    bus.ch_event = v.ev;
    sb.push_back(mkExp(v.seg, int'(v.shown), cyc + LAT, tag));
    if (v.ev != 3'b000) sb.push_back(mkExp(cur0_seg, 0, cyc + HOLD + LAT, tag + 100));
    else cur0_seg = v.seg;
    @(posedge clk);
    #1;
    bus.ch_event = '0;
  endtask

  task automatic holdSequence(input logic [2:0] ev, input int ch, input logic [NDIG*7-1:0] s,
                              input int repulse_at, input int tag);
    int t0;
    t0 = cyc;
    bus.ch_event = ev;
    sb.push_back(mkExp(s, ch, t0 + LAT, tag));
    sb.push_back(mkExp(cur0_seg, 0, t0 + repulse_at + HOLD + LAT, tag + 100));
    @(posedge clk);
    #1;
    bus.ch_event = '0;
    waitUntil(t0 + repulse_at);
    bus.ch_event = 3'(1 << ch);
    @(posedge clk);
    #1;
    bus.ch_event = '0;
    waitUntil(t0 + repulse_at + 60);
    checkValue("hold_shown_ch", 64'(bus.shown_ch), 64'(ch));
    waitDrain(HOLD + repulse_at + 4 * LAT);
  endtask

  initial begin
    repeat (30000) @(posedge clk);
    $display("[TB] FAIL watchdog: simulation still running at cycle %0d, required completion", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t0;
    vecs[0]  = mkVec(3'b000, 0, 16'd42,    s2seg("    42"), 0);
    vecs[1]  = mkVec(3'b000, 0, 16'd0,     s2seg("     0"), 0);
    vecs[2]  = mkVec(3'b000, 0, 16'd7,     s2seg("     7"), 0);
    vecs[3]  = mkVec(3'b000, 0, 16'd10000, s2seg(" 10000"), 0);
    vecs[4]  = mkVec(3'b000, 0, 16'd65535, s2seg(" 65535"), 0);
    vecs[5]  = mkVec(3'b000, 0, 16'd50809, s2seg(" 50809"), 0);
    vecs[6]  = mkVec(3'b010, 1, 16'd65535, s2seg("P65535"), 1);
    vecs[7]  = mkVec(3'b110, 2, 16'd123,   s2seg("L  123"), 2);
    vecs[8]  = mkVec(3'b011, 1, 16'd321,   s2seg("P  321"), 1);
    vecs[9]  = mkVec(3'b000, 0, 16'd1000,  s2seg("  1000"), 0);
    vecs[10] = mkVec(3'b100, 2, 16'd0,     s2seg("L    0"), 2);

    rst_n         = 1'b0;
    bus.ch_data   = '0;
    bus.ch_event  = '0;
    bus5.ch_data  = '0;
    bus5.ch_event = '0;
    bus.ch_data[DW-1:0] = 16'd1234;
    cur0_seg = {7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30, 7'h19};

    // Reset state and first conversion out of reset.
    repeat (3) @(posedge clk);
    #1;
    checkValue("reset_seg", 64'(bus.seg), 64'(BLANK));
    checkValue("reset_shown_ch", 64'(bus.shown_ch), 64'd0);
    checkValue("reset_busy", 64'(bus.busy), 64'd0);
    sb.push_back(mkExp(cur0_seg, 0, cyc + LAT, 1));
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checkValue("busy_mid_conv", 64'(bus.busy), 64'd1);
    checkValue("seg_blank_mid_conv", 64'(bus.seg), 64'(BLANK));
    waitDrain(4 * LAT);

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i], i + 10);
      waitDrain(HOLD + 4 * LAT);
    end

    // Re-pulse inside the hold window extends it; a re-pulse on the expiry
    // cycle itself must keep the channel selected.
    holdSequence(3'b110, 2, s2seg("L    0"), 90, 30);
    holdSequence(3'b010, 1, s2seg("P  321"), 100, 31);

    // Input change mid-conversion: old value commits, then the new one.
    t0 = cyc;
    bus.ch_data[DW-1:0] = 16'd1234;
    sb.push_back(mkExp(s2seg("  1234"), 0, t0 + LAT, 40));
    sb.push_back(mkExp(s2seg("    42"), 0, t0 + 2 * LAT, 41));
    repeat (5) @(posedge clk);
    #1;
    bus.ch_data[DW-1:0] = 16'd42;
    waitDrain(4 * LAT);
    cur0_seg = s2seg("    42");

    // Reset in the middle of a conversion while an event channel is shown.
    t0 = cyc;
    bus.ch_data[DW +: DW] = 16'd555;
    bus.ch_event = 3'b010;
    sb.push_back(mkExp(s2seg("P  555"), 1, t0 + LAT, 50));
    @(posedge clk);
    #1;
    bus.ch_event = '0;
    waitDrain(4 * LAT);
    bus.ch_data[DW +: DW] = 16'd777;
    repeat (5) @(posedge clk);
    #1;
    checkValue("busy_before_reset", 64'(bus.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    checkValue("midconv_reset_seg", 64'(bus.seg), 64'(BLANK));
    checkValue("midconv_reset_busy", 64'(bus.busy), 64'd0);
    checkValue("midconv_reset_shown_ch", 64'(bus.shown_ch), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    checkValue("held_reset_seg", 64'(bus.seg), 64'(BLANK));
    sb.push_back(mkExp(cur0_seg, 0, cyc + LAT, 51));
    rst_n = 1'b1;
    waitDrain(4 * LAT);

    // Wider instance: overflow boundary at 10^5.
    repeat (10) @(posedge clk);
    #1;
    checkValue("w20_initial_zero", 64'(bus5.seg), 64'(s2seg("     0")));
    bus5.ch_data[DW5-1:0] = 20'd100000;
    @(posedge clk);
    #1;
    checkValue("w20_ovf_busy", 64'(bus5.busy), 64'd1);
    checkValue("w20_ovf_seg_old", 64'(bus5.seg), 64'(s2seg("     0")));
    @(posedge clk);
    #1;
    checkValue("w20_ovf_dashes", 64'(bus5.seg), 64'(s2seg(" -----")));
    checkValue("w20_ovf_done", 64'(bus5.busy), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    t0 = cyc;
    bus5.ch_data[DW5-1:0] = 20'd99999;
    waitUntil(t0 + LAT5 - 1);
    checkValue("w20_max_not_yet", 64'(bus5.seg), 64'(s2seg(" -----")));
    waitUntil(t0 + LAT5);
    checkValue("w20_max_value", 64'(bus5.seg), 64'(s2seg(" 99999")));
    checkValue("w20_max_done", 64'(bus5.busy), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    bus5.ch_data[DW5-1:0] = 20'd1048575;
    repeat (2) @(posedge clk);
    #1;
    checkValue("w20_full_scale_dashes", 64'(bus5.seg), 64'(s2seg(" -----")));

    repeat (5) @(posedge clk);
    #1;
    checkValue("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
